// File: rtl/mc_add_sched.sv
// Round-robin scheduler driving wide add/sub through a shared SLICE_W adder, LSB slice first.
// Latency: grant at T, res_valid pulse at T+NSLICE+1; ready only in IDLE, so a requester stalls while an op is in flight.
module mc_add_sched #(
  parameter int WIDTH   = 128,
  parameter int SLICE_W = 32,
  localparam int NSLICE = WIDTH / SLICE_W,
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req0_sub,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic               req1_sub,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic               add_cin,
  input  logic [SLICE_W-1:0] add_sum,
  input  logic               add_cout,
  output logic               res_valid,
  output logic               res_id,
  output logic [WIDTH-1:0]   res_sum,
  output logic               res_cout,
  output logic               res_ovf,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state_q;
  logic [IDXW-1:0]                 idx_q;
  logic                            carry_q;
  logic                            last_grant_q;
  logic                            id_q;
  logic [NSLICE-1:0][SLICE_W-1:0]  a_q;
  logic [NSLICE-1:0][SLICE_W-1:0]  b_q;
  logic [NSLICE-1:0][SLICE_W-1:0]  res_sum_q;
  logic                            res_valid_q;
  logic                            res_id_q;
  logic                            res_cout_q;
  logic                            res_ovf_q;

  logic grant0, grant1, last_slice, res_ovf_d;

  // On a tie the requester that did not win last time is served.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;

  assign add_a   = (state_q == RUN) ? a_q[idx_q] : '0;
  assign add_b   = (state_q == RUN) ? b_q[idx_q] : '0;
  assign add_cin = (state_q == RUN) ? carry_q : 1'b0;

  assign last_slice = (idx_q == IDXW'(NSLICE - 1));
  // b_q already holds ~b for subtract, so one rule covers both operations.
  assign res_ovf_d  = (a_q[NSLICE-1][SLICE_W-1] == b_q[NSLICE-1][SLICE_W-1]) &&
                      (add_sum[SLICE_W-1] != a_q[NSLICE-1][SLICE_W-1]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_sum_q    <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_cout_q   <= 1'b0;
      res_ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          res_valid_q <= 1'b0;
          if (grant0 || grant1) begin
            a_q          <= grant1 ? req1_a : req0_a;
            b_q          <= grant1 ? (req1_sub ? ~req1_b : req1_b)
                                   : (req0_sub ? ~req0_b : req0_b);
            carry_q      <= grant1 ? req1_sub : req0_sub;
            id_q         <= grant1;
            last_grant_q <= grant1;
            idx_q        <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          res_sum_q[idx_q] <= add_sum;
          carry_q          <= add_cout;
          idx_q            <= idx_q + 1'b1;
          if (last_slice) begin
            res_cout_q  <= add_cout;
            res_ovf_q   <= res_ovf_d;
            res_id_q    <= id_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_ovf   = res_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mc_add_sched.sv
// Scoreboard bench for mc_add_sched with a behavioural model of the shared adder and of wide add/sub.
module tb_mc_add_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic [31:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         res_valid, res_id, res_cout, res_ovf, busy;
  logic [127:0] res_sum;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit           id;
    logic [127:0] sum;
    bit           cout;
    bit           ovf;
    int           cyc;
  } exp_t;

  exp_t q[$];

  mc_add_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
    .busy(busy)
  );

  // The shared external 32-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic exp_t model(input bit id, input logic [127:0] a, input logic [127:0] b,
                                 input bit sub, input int c);
    exp_t e;
    logic [128:0]        w;
    logic signed [129:0] sa, sb, s;
    sa = $signed({{2{a[127]}}, a});
    sb = $signed({{2{b[127]}}, b});
    if (!sub) begin
      w      = {1'b0, a} + {1'b0, b};
      e.sum  = w[127:0];
      e.cout = w[128];
      s      = sa + sb;
    end else begin
      e.sum  = a - b;
      e.cout = (a >= b);
      s      = sa - sb;
    end
    e.ovf = (s > $signed({3'b000, {127{1'b1}}})) || (s < $signed({3'b111, {127{1'b0}}}));
    e.id  = id;
    e.cyc = c;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Monitor: records accepted operations and compares every result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q.delete();
    end else begin
      if (req0_ready || req1_ready) begin
        tests++;
        if ((req0_ready && req1_ready) || busy) begin
          fails++;
          $display("FAIL ready_rule got r0=%0b r1=%0b busy=%0b required one ready and busy=0",
                   req0_ready, req1_ready, busy);
        end
      end
      if (req0_valid && req0_ready) q.push_back(model(1'b0, req0_a, req0_b, req0_sub, cyc));
      if (req1_valid && req1_ready) q.push_back(model(1'b1, req1_a, req1_b, req1_sub, cyc));
      if (res_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_res got res_valid=1 required no result pending");
        end else begin
          e = q.pop_front();
          check("res_id",   128'(res_id),   128'(e.id));
          check("res_sum",  res_sum,        e.sum);
          check("res_cout", 128'(res_cout), 128'(e.cout));
          check("res_ovf",  128'(res_ovf),  128'(e.ovf));
          check("latency",  128'(cyc - e.cyc), 128'(5));
        end
      end
    end
  end

  task automatic set_req(input bit id, input logic [127:0] a, input logic [127:0] b,
                         input bit sub, input bit v);
    if (id) begin
      req1_a = a; req1_b = b; req1_sub = sub; req1_valid = v;
    end else begin
      req0_a = a; req0_b = b; req0_sub = sub; req0_valid = v;
    end
  endtask

  task automatic issue(input bit id, input logic [127:0] a, input logic [127:0] b, input bit sub);
    bit got;
    got = 1'b0;
    set_req(id, a, b, sub, 1'b1);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    @(posedge clk);
    #1;
    // Scramble the inputs after acceptance: the DUT must have latched them.
    set_req(id, r128(), r128(), 1'($urandom), 1'b0);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL issue_timeout id=%0d got no ready, required ready within 40 cycles", id);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      done = !busy && (q.size() == 0);
    end
    @(posedge clk);
    #1;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL wait_idle got busy=%0b pending=%0d required idle with none pending", busy, q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},      128'(busy),      128'(0));
    check({tag, "_res_valid"}, 128'(res_valid), 128'(0));
    check({tag, "_res_id"},    128'(res_id),    128'(0));
    check({tag, "_res_sum"},   res_sum,         128'(0));
    check({tag, "_res_cout"},  128'(res_cout),  128'(0));
    check({tag, "_res_ovf"},   128'(res_ovf),   128'(0));
    check({tag, "_add_ab"},    {add_a, add_b},  128'(0));
    check({tag, "_add_cin"},   128'(add_cin),   128'(0));
  endtask

  initial begin
    logic [127:0] ones, smax, smin, a, b;
    bit           nexp, g;
    int           k, last;
    ones = '1;
    smax = {1'b0, {127{1'b1}}};
    smin = {1'b1, {127{1'b0}}};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed operations.
    issue(1'b0, 128'hFFFF_FFFF, 128'd1, 1'b0);
    issue(1'b1, ones, 128'd1, 1'b0);
    issue(1'b0, 128'd5, 128'd7, 1'b1);
    issue(1'b0, 128'd7, 128'd5, 1'b1);
    issue(1'b1, smax, 128'd1, 1'b0);
    issue(1'b0, smin, 128'd1, 1'b1);
    issue(1'b1, r128(), 128'd0, 1'b1);
    issue(1'b0, ones, ones, 1'b0);
    wait_idle();

    // Both requesters held valid from reset: grants must alternate 0,1,0,1 every 6 cycles.
    do_reset();
    set_req(1'b0, r128(), r128(), 1'($urandom), 1'b1);
    set_req(1'b1, r128(), r128(), 1'($urandom), 1'b1);
    nexp = 1'b0;
    k    = 0;
    last = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        check("arb_id", 128'(g), 128'(nexp));
        if (k > 0) check("arb_spacing", 128'(cyc - last), 128'(6));
        last = cyc;
        nexp = ~nexp;
        k++;
        @(posedge clk);
        #1;
        set_req(g, r128(), r128(), 1'($urandom), 1'b1);
      end
    end
    check("arb_grants", 128'(k), 128'(4));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Requester 1 alone, three times.
    for (int i = 0; i < 3; i++) issue(1'b1, r128(), r128(), 1'($urandom));
    wait_idle();

    // Randomised traffic with boundary operands mixed in.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: a = ones;
        1: a = smax;
        2: a = smin;
        default: a = r128();
      endcase
      case ($urandom_range(0, 4))
        0: b = 128'd0;
        1: b = 128'd1;
        2: b = a;
        default: b = r128();
      endcase
      issue(1'($urandom), a, b, 1'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    // Reset during RUN slice 2 aborts the operation silently.
    issue(1'b0, r128(), r128(), 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    issue(1'b0, 128'hFFFF_FFFF, 128'd1, 1'b0);
    wait_idle();

    check("final_pending", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog got no completion, required finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
